// File: rtl/cpu_pkg.sv
// Shared pipeline constants: datapath widths, register zero, bubble fill and
// the forwarding-select encoding also consumed by the hazard unit.
package cpu_pkg;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int TW = 2;

  localparam logic [AW-1:0] REG_ZERO = '0;

  // Every field of an E-stage bubble is filled with this bit.
  localparam logic BUBBLE_BIT = 1'b0;

  typedef enum logic [1:0] {
    FWD_RF = 2'd0,
    FWD_W  = 2'd1,
    FWD_M  = 2'd2,
    FWD_E  = 2'd3
  } fwd_sel_e;

endpackage

// File: rtl/de_pipe_reg_if.sv
// D-stage inputs, forwarding sources and E-stage register outputs of the D/E boundary.
// The slave modport is the pipeline register; the master modport drives it.
interface de_pipe_reg_if #(
  parameter int DW = cpu_pkg::DW,
  parameter int AW = cpu_pkg::AW,
  parameter int TW = cpu_pkg::TW
);

  logic          hold;
  logic          stall;
  logic          flush;
  logic [DW-1:0] instr_d;
  logic [DW-1:0] pc8_d;
  logic [AW-1:0] a1_d;
  logic [AW-1:0] a2_d;
  logic [DW-1:0] rd1_d;
  logic [DW-1:0] rd2_d;
  logic [AW-1:0] a3_d;
  logic          we_d;
  logic [TW-1:0] tnew_d;

  logic          fe_we;
  logic          fm_we;
  logic          fw_we;
  logic [AW-1:0] fe_addr;
  logic [AW-1:0] fm_addr;
  logic [AW-1:0] fw_addr;
  logic [DW-1:0] fe_data;
  logic [DW-1:0] fm_data;
  logic [DW-1:0] fw_data;

  logic [DW-1:0] rs_fwd_d;
  logic [DW-1:0] rt_fwd_d;

  logic [DW-1:0] instr_e;
  logic [DW-1:0] pc8_e;
  logic [DW-1:0] rs_e;
  logic [DW-1:0] rt_e;
  logic [AW-1:0] a3_e;
  logic          we_e;
  logic          valid_e;
  logic [TW-1:0] tnew_e;

  modport slave (
    input  hold, stall, flush,
    input  instr_d, pc8_d, a1_d, a2_d, rd1_d, rd2_d, a3_d, we_d, tnew_d,
    input  fe_we, fm_we, fw_we, fe_addr, fm_addr, fw_addr, fe_data, fm_data, fw_data,
    output rs_fwd_d, rt_fwd_d,
    output instr_e, pc8_e, rs_e, rt_e, a3_e, we_e, valid_e, tnew_e
  );

  modport master (
    output hold, stall, flush,
    output instr_d, pc8_d, a1_d, a2_d, rd1_d, rd2_d, a3_d, we_d, tnew_d,
    output fe_we, fm_we, fw_we, fe_addr, fm_addr, fw_addr, fe_data, fm_data, fw_data,
    input  rs_fwd_d, rt_fwd_d,
    input  instr_e, pc8_e, rs_e, rt_e, a3_e, we_e, valid_e, tnew_e
  );

endinterface

// File: rtl/fwd_mux.sv
// One Decode operand forwarder: E > M > W > RF, register 0 always reads 0.
// Combinational; W source only participates when WB_BYPASS_EN is defined.
module fwd_mux
  import cpu_pkg::*;
#(
  parameter int DW = cpu_pkg::DW,
  parameter int AW = cpu_pkg::AW
) (
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] rf_data,
  input  logic          e_we,
  input  logic [AW-1:0] e_addr,
  input  logic [DW-1:0] e_data,
  input  logic          m_we,
  input  logic [AW-1:0] m_addr,
  input  logic [DW-1:0] m_data,
  input  logic          w_we,
  input  logic [AW-1:0] w_addr,
  input  logic [DW-1:0] w_data,
  output logic [DW-1:0] fwd_data,
  output fwd_sel_e      fwd_sel
);

`ifndef WB_BYPASS_EN
  logic unused_w;
  assign unused_w = ^{w_we, w_addr, w_data};
`endif

  // addr is nonzero in every match branch, so a source at register 0 never hits.
  always_comb begin
    fwd_data = rf_data;
    fwd_sel  = FWD_RF;
    if (addr == REG_ZERO) begin
      fwd_data = '0;
      fwd_sel  = FWD_RF;
    end else if (e_we && (e_addr == addr)) begin
      fwd_data = e_data;
      fwd_sel  = FWD_E;
    end else if (m_we && (m_addr == addr)) begin
      fwd_data = m_data;
      fwd_sel  = FWD_M;
`ifdef WB_BYPASS_EN
    end else if (w_we && (w_addr == addr)) begin
      fwd_data = w_data;
      fwd_sel  = FWD_W;
`endif
    end
  end

endmodule

// File: rtl/de_pipe_reg.sv
// Decode-to-Execute pipeline register with Decode operand forwarding (WB_BYPASS_EN adds W source).
// 1-cycle D->E latency; priority reset > flush > hold > stall > load, stall/flush insert a bubble.
module de_pipe_reg
  import cpu_pkg::*;
#(
  parameter int DW = cpu_pkg::DW,
  parameter int AW = cpu_pkg::AW,
  parameter int TW = cpu_pkg::TW
) (
  input  logic             clk,
  input  logic             reset,
  de_pipe_reg_if.slave     bus
);

  typedef struct packed {
    logic [DW-1:0] instr;
    logic [DW-1:0] pc8;
    logic [DW-1:0] rs;
    logic [DW-1:0] rt;
    logic [AW-1:0] a3;
    logic          we;
    logic          valid;
    logic [TW-1:0] tnew;
  } e_reg_t;

  localparam e_reg_t E_BUBBLE = {$bits(e_reg_t){BUBBLE_BIT}};

  fwd_sel_e rs_sel;
  fwd_sel_e rt_sel;
  logic     unused_sel;

  // Select codes are for the hazard unit; this block only needs the data.
  assign unused_sel = ^{rs_sel, rt_sel};

  fwd_mux #(.DW(DW), .AW(AW)) u_fwd_rs (
    .addr     (bus.a1_d),
    .rf_data  (bus.rd1_d),
    .e_we     (bus.fe_we),
    .e_addr   (bus.fe_addr),
    .e_data   (bus.fe_data),
    .m_we     (bus.fm_we),
    .m_addr   (bus.fm_addr),
    .m_data   (bus.fm_data),
    .w_we     (bus.fw_we),
    .w_addr   (bus.fw_addr),
    .w_data   (bus.fw_data),
    .fwd_data (bus.rs_fwd_d),
    .fwd_sel  (rs_sel)
  );

  fwd_mux #(.DW(DW), .AW(AW)) u_fwd_rt (
    .addr     (bus.a2_d),
    .rf_data  (bus.rd2_d),
    .e_we     (bus.fe_we),
    .e_addr   (bus.fe_addr),
    .e_data   (bus.fe_data),
    .m_we     (bus.fm_we),
    .m_addr   (bus.fm_addr),
    .m_data   (bus.fm_data),
    .w_we     (bus.fw_we),
    .w_addr   (bus.fw_addr),
    .w_data   (bus.fw_data),
    .fwd_data (bus.rt_fwd_d),
    .fwd_sel  (rt_sel)
  );

  e_reg_t e_q;
  e_reg_t e_d;

  always_comb begin
    e_d = e_q;
    if (bus.flush) begin
      e_d = E_BUBBLE;
    end else if (bus.hold) begin
      e_d = e_q;
    end else if (bus.stall) begin
      e_d = E_BUBBLE;
    end else begin
      e_d.instr = bus.instr_d;
      e_d.pc8   = bus.pc8_d;
      e_d.rs    = bus.rs_fwd_d;
      e_d.rt    = bus.rt_fwd_d;
      // A write to register 0 is dropped here so downstream never forwards it.
      e_d.a3    = bus.we_d ? bus.a3_d : REG_ZERO;
      e_d.we    = bus.we_d && (bus.a3_d != REG_ZERO);
      e_d.tnew  = bus.tnew_d;
      e_d.valid = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      e_q <= E_BUBBLE;
    end else begin
      e_q <= e_d;
    end
  end

  assign bus.instr_e = e_q.instr;
  assign bus.pc8_e   = e_q.pc8;
  assign bus.rs_e    = e_q.rs;
  assign bus.rt_e    = e_q.rt;
  assign bus.a3_e    = e_q.a3;
  assign bus.we_e    = e_q.we;
  assign bus.valid_e = e_q.valid;
  assign bus.tnew_e  = e_q.tnew;

endmodule

// File: tb/tb_de_pipe_reg.sv
// Directed bench for de_pipe_reg: reset, forwarding priority, register 0, hold/stall/flush, W edge.
module tb_de_pipe_reg;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fails;

  de_pipe_reg_if bus ();

  de_pipe_reg dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_srcs();
    bus.fe_we = 1'b0; bus.fe_addr = '0; bus.fe_data = '0;
    bus.fm_we = 1'b0; bus.fm_addr = '0; bus.fm_data = '0;
    bus.fw_we = 1'b0; bus.fw_addr = '0; bus.fw_data = '0;
  endtask

  logic [31:0] exp_w;
  logic [31:0] exp_wedge;

  initial begin
    n_checks = 0;
    n_fails  = 0;
`ifdef WB_BYPASS_EN
    exp_w     = 32'hCC;
    exp_wedge = 32'h1234;
`else
    exp_w     = 32'h11;
    exp_wedge = 32'h0;
`endif
    reset = 1'b1;
    bus.hold = 1'b0; bus.stall = 1'b0; bus.flush = 1'b0;
    bus.instr_d = 32'h8C22_0004; bus.pc8_d = 32'h3008;
    bus.a1_d = 5'd0; bus.a2_d = 5'd0; bus.rd1_d = '0; bus.rd2_d = '0;
    bus.a3_d = 5'd2; bus.we_d = 1'b1; bus.tnew_d = 2'd2;
    clear_srcs();

    tick(); tick();
    check_eq("rst_instr_e", bus.instr_e, 0);
    check_eq("rst_pc8_e", bus.pc8_e, 0);
    check_eq("rst_valid_e", bus.valid_e, 0);
    check_eq("rst_we_e", bus.we_e, 0);
    check_eq("rst_a3_e", bus.a3_e, 0);
    check_eq("rst_tnew_e", bus.tnew_e, 0);

    reset = 1'b0;
    tick();
    check_eq("load_instr_e", bus.instr_e, 32'h8C22_0004);
    check_eq("load_valid_e", bus.valid_e, 1);
    check_eq("load_we_e", bus.we_e, 1);
    check_eq("load_a3_e", bus.a3_e, 2);
    check_eq("load_tnew_e", bus.tnew_e, 2);

    // forwarding priority E > M > W > RF on both operands
    bus.a1_d = 5'd3; bus.rd1_d = 32'h11;
    bus.a2_d = 5'd3; bus.rd2_d = 32'h22;
    bus.fe_we = 1'b1; bus.fe_addr = 5'd3; bus.fe_data = 32'hAA;
    bus.fm_we = 1'b1; bus.fm_addr = 5'd3; bus.fm_data = 32'hBB;
    bus.fw_we = 1'b1; bus.fw_addr = 5'd3; bus.fw_data = 32'hCC;
    #1;
    check_eq("fwd_e_rs", bus.rs_fwd_d, 32'hAA);
    check_eq("fwd_e_rt", bus.rt_fwd_d, 32'hAA);
    tick();
    check_eq("fwd_e_rs_e", bus.rs_e, 32'hAA);
    bus.fe_we = 1'b0;
    #1;
    check_eq("fwd_m_rs", bus.rs_fwd_d, 32'hBB);
    tick();
    check_eq("fwd_m_rt_e", bus.rt_e, 32'hBB);
    bus.fm_we = 1'b0;
    #1;
    check_eq("fwd_w_rs", bus.rs_fwd_d, exp_w);
    bus.fw_we = 1'b0;
    #1;
    check_eq("fwd_rf_rs", bus.rs_fwd_d, 32'h11);
    check_eq("fwd_rf_rt", bus.rt_fwd_d, 32'h22);

    // register 0 never forwards, and a zero destination is not written
    clear_srcs();
    bus.a2_d = 5'd0; bus.rd2_d = 32'h5;
    bus.fe_we = 1'b1; bus.fe_addr = 5'd0; bus.fe_data = 32'hFF;
    #1;
    check_eq("r0_rt_fwd", bus.rt_fwd_d, 0);
    bus.a2_d = 5'd4;
    #1;
    check_eq("src0_nomatch", bus.rt_fwd_d, 32'h5);
    bus.a3_d = 5'd0; bus.we_d = 1'b1;
    tick();
    check_eq("r0_we_e", bus.we_e, 0);
    check_eq("r0_a3_e", bus.a3_e, 0);
    bus.a3_d = 5'd7; bus.we_d = 1'b0;
    tick();
    check_eq("nowe_a3_e", bus.a3_e, 0);
    check_eq("nowe_we_e", bus.we_e, 0);

    // hold beats stall, then stall inserts a bubble
    clear_srcs();
    bus.pc8_d = 32'h3008;
    tick();
    check_eq("st_pc8_load", bus.pc8_e, 32'h3008);
    bus.hold = 1'b1; bus.stall = 1'b1; bus.pc8_d = 32'h300C;
    tick();
    check_eq("hold_pc8_e", bus.pc8_e, 32'h3008);
    check_eq("hold_valid_e", bus.valid_e, 1);
    bus.hold = 1'b0;
    tick();
    check_eq("stall_pc8_e", bus.pc8_e, 0);
    check_eq("stall_valid_e", bus.valid_e, 0);
    bus.stall = 1'b0;
    tick();
    check_eq("resume_pc8_e", bus.pc8_e, 32'h300C);
    check_eq("resume_valid_e", bus.valid_e, 1);

    // flush wins over hold
    bus.hold = 1'b1; bus.flush = 1'b1;
    tick();
    check_eq("flush_valid_e", bus.valid_e, 0);
    check_eq("flush_instr_e", bus.instr_e, 0);
    bus.hold = 1'b0; bus.flush = 1'b0;
    tick();
    check_eq("reload_valid_e", bus.valid_e, 1);

    // reset wins over hold
    bus.hold = 1'b1; reset = 1'b1;
    tick();
    check_eq("rsthold_valid_e", bus.valid_e, 0);
    check_eq("rsthold_pc8_e", bus.pc8_e, 0);
    bus.hold = 1'b0; reset = 1'b0;

    // W result visible to Decode only through the bypass
    clear_srcs();
    bus.fw_we = 1'b1; bus.fw_addr = 5'd8; bus.fw_data = 32'h1234;
    bus.a1_d = 5'd8; bus.rd1_d = 32'h0;
    tick();
    check_eq("wedge_rs_e", bus.rs_e, exp_wedge);
    check_eq("wedge_valid_e", bus.valid_e, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

endmodule
